hex_entry_sequencer: RTL

//  Controller for the six-digit HEX display and LED bank on the board top level.
//  It debounces the two push keys and captures 4-bit switch values into a 6-digit buffer.
//  It sequences the buffer onto HEX0..HEX5, either as static entry or as a timed rotating scroll.
//  It drives status LEDs and replaces the constant segment patterns driven from the top level.

---
 rtl/hex_entry_sequencer.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/hex_entry_sequencer.sv
// Six-digit hex entry and scroll controller for the board HEX displays and LEDs.
// Two push keys are synchronized and debounced. Enter pushes switch[3:0] into a
// six-slot shift buffer, or clears the buffer when switch[7] is set. Mode toggles
// between static entry and a timed rotating scroll. Segments and LEDs are registered.
//
// Key handshake: press pulses are single-cycle strobes with no back-pressure.
// A pulse is consumed in the cycle it is high. Nothing is held or queued.
module hex_entry_sequencer #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int TICK_CYCLES     = 25000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] key,
   input  logic [7:0] switch,
   output logic [7:0] hex0,
   output logic [7:0] hex1,
   output logic [7:0] hex2,
   output logic [7:0] hex3,
   output logic [7:0] hex4,
   output logic [7:0] hex5,
   output logic [9:0] leds,
   output logic       dbg_state_o
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int TW = $clog2(TICK_CYCLES + 1);
   localparam logic [DW-1:0] DB_MAX   = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TW-1:0] TICK_MAX = TW'(TICK_CYCLES - 1);

   typedef enum logic {
      ST_ENTRY  = 1'b0,
      ST_SCROLL = 1'b1
   } state_t;

   // ---------------------------------------------------------------
   // Key conditioning
   // ---------------------------------------------------------------
   logic [1:0]    sync1_q;
   logic [1:0]    sync2_q;
   logic [1:0]    stable_q;
   logic [1:0]    armed_q;
   logic [1:0]    press_q;
   logic [DW-1:0] db_cnt_q [2];

   // Synchronize and debounce both keys, emitting a pulse on an accepted press.
   // The synchronizer resets to "pressed" so that only a real sampled release
   // can arm a key. A key held through reset therefore yields no pulse until it
   // has been released and pressed again.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q     <= 2'b00;
         sync2_q     <= 2'b00;
         stable_q    <= 2'b11;
         armed_q     <= 2'b00;
         press_q     <= 2'b00;
         db_cnt_q[0] <= '0;
         db_cnt_q[1] <= '0;
      end else begin
         sync1_q <= key;
         sync2_q <= sync1_q;
         armed_q <= armed_q | sync2_q;
         for (int i = 0; i < 2; i++) begin
            press_q[i] <= 1'b0;
            if (sync2_q[i] == stable_q[i]) begin
               db_cnt_q[i] <= '0;
            end else if (db_cnt_q[i] == DB_MAX) begin
               db_cnt_q[i] <= '0;
               stable_q[i] <= sync2_q[i];
               press_q[i]  <= ~sync2_q[i] & armed_q[i];
            end else begin
               db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
            end
         end
      end
   end

   logic enter_p;
   logic mode_p;
   logic clear_p;
   assign enter_p = press_q[0];
   assign mode_p  = press_q[1];
   assign clear_p = enter_p & switch[7];

   // ---------------------------------------------------------------
   // Control FSM and digit buffer
   // ---------------------------------------------------------------
   state_t        state_q;
   logic [5:0]    valid_q;
   logic [3:0]    nib_q [6];
   logic [2:0]    count_q;
   logic [TW-1:0] tick_q;

   // Clear beats mode, mode beats push. Scroll rotation includes invalid slots.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_ENTRY;
         valid_q <= 6'b0;
         count_q <= 3'd0;
         tick_q  <= '0;
         for (int i = 0; i < 6; i++) begin
            nib_q[i] <= 4'h0;
         end
      end else if (clear_p) begin
         state_q <= ST_ENTRY;
         valid_q <= 6'b0;
         count_q <= 3'd0;
         tick_q  <= '0;
      end else if (mode_p) begin
         state_q <= (state_q == ST_ENTRY) ? ST_SCROLL : ST_ENTRY;
         tick_q  <= '0;
      end else if (state_q == ST_ENTRY) begin
         tick_q <= '0;
         if (enter_p) begin
            for (int i = 5; i > 0; i--) begin
               valid_q[i] <= valid_q[i-1];
               nib_q[i]   <= nib_q[i-1];
            end
            valid_q[0] <= 1'b1;
            nib_q[0]   <= switch[3:0];
            count_q    <= (count_q == 3'd6) ? 3'd6 : count_q + 3'd1;
         end
      end else begin
         if (tick_q == TICK_MAX) begin
            tick_q <= '0;
            for (int i = 5; i > 0; i--) begin
               valid_q[i] <= valid_q[i-1];
               nib_q[i]   <= nib_q[i-1];
            end
            valid_q[0] <= valid_q[5];
            nib_q[0]   <= nib_q[5];
         end else begin
            tick_q <= tick_q + 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------
   // Output decode
   // ---------------------------------------------------------------
   function automatic logic [6:0] glyph(input logic [3:0] n);
      logic [6:0] g;
      case (n)
         4'h0: g = 7'h40;
         4'h1: g = 7'h79;
         4'h2: g = 7'h24;
         4'h3: g = 7'h30;
         4'h4: g = 7'h19;
         4'h5: g = 7'h12;
         4'h6: g = 7'h02;
         4'h7: g = 7'h78;
         4'h8: g = 7'h00;
         4'h9: g = 7'h10;
         4'hA: g = 7'h08;
         4'hB: g = 7'h03;
         4'hC: g = 7'h46;
         4'hD: g = 7'h21;
         4'hE: g = 7'h06;
         default: g = 7'h0E;
      endcase
      return g;
   endfunction

   logic [7:0] hex_q [6];
   logic [9:0] leds_q;
   logic       scroll;
   assign scroll = (state_q == ST_SCROLL);

   // Register segment patterns and LEDs one cycle behind the buffer.
   // The hex0 decimal point marks scroll mode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 6; i++) begin
            hex_q[i] <= 8'hFF;
         end
         leds_q <= 10'h000;
      end else begin
         for (int i = 0; i < 6; i++) begin
            hex_q[i][6:0] <= valid_q[i] ? glyph(nib_q[i]) : 7'h7F;
            hex_q[i][7]   <= (i == 0) ? ~scroll : 1'b1;
         end
         leds_q <= {(count_q == 3'd6), scroll, 5'b00000, count_q};
      end
   end

   assign hex0        = hex_q[0];
   assign hex1        = hex_q[1];
   assign hex2        = hex_q[2];
   assign hex3        = hex_q[3];
   assign hex4        = hex_q[4];
   assign hex5        = hex_q[5];
   assign leds        = leds_q;
   assign dbg_state_o = state_q;

endmodule
